// File: rtl/vocab_matcher_pkg.sv
// Shared types for the vocabulary matcher: FSM state encoding, default word type, stats width.
package matcher_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int DEF_DATA_WIDTH  = 8;
    localparam int DEF_WORD_LENGTH = 3;
    localparam int DEF_WORD_WIDTH  = DEF_DATA_WIDTH * DEF_WORD_LENGTH;

    typedef logic [DEF_WORD_WIDTH-1:0] word_t;

    localparam int STAT_WIDTH = 32;

endpackage

// File: rtl/vocab_matcher_store.sv
// Vocabulary storage: word array (not reset) plus per-entry valid bits, with one write
// port and a combinational LANES-wide read of a whole group.
module vocab_store
    import matcher_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int WORD_LENGTH = 3,
    parameter int ADDR_WIDTH  = 4,
    parameter int LANES       = 2,
    parameter int GW          = 3
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        clear_i,
    input  logic                                        wr_en_i,
    input  logic [ADDR_WIDTH-1:0]                       wr_addr_i,
    input  logic [DATA_WIDTH*WORD_LENGTH-1:0]           wr_word_i,
    input  logic [GW-1:0]                               rd_group_i,
    output logic [LANES-1:0][DATA_WIDTH*WORD_LENGTH-1:0] rd_words_o,
    output logic [LANES-1:0]                            rd_valid_o
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int W     = DATA_WIDTH * WORD_LENGTH;

    logic [W-1:0]     mem_q [DEPTH];
    logic [DEPTH-1:0] valid_q;

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_word_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (clear_i) begin
            valid_q <= '0;
        end else if (wr_en_i) begin
            valid_q[wr_addr_i] <= 1'b1;
        end
    end

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic [ADDR_WIDTH-1:0] rd_addr;
            assign rd_addr        = ADDR_WIDTH'(int'(rd_group_i) * LANES + gi);
            assign rd_words_o[gi] = mem_q[rd_addr];
            assign rd_valid_o[gi] = valid_q[rd_addr];
        end
    endgenerate

endmodule

// File: rtl/vocab_matcher.sv
// Multi-lane vocabulary lookup: scans LANES entries per cycle, stops at first match,
// first invalid entry (terminator) or last group. Optional stats via VOCAB_MATCHER_STATS_EN.
module vocab_matcher
    import matcher_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int WORD_LENGTH = 3,
    parameter int ADDR_WIDTH  = 4,
    parameter int LANES       = 2
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                clear,
    input  logic                                wr_en,
    input  logic [ADDR_WIDTH-1:0]               wr_addr,
    input  logic [WORD_LENGTH*DATA_WIDTH-1:0]   wr_word,
    input  logic                                req_valid,
    output logic                                req_ready,
    input  logic [WORD_LENGTH*DATA_WIDTH-1:0]   req_word,
    output logic                                rsp_valid,
    input  logic                                rsp_ready,
    output logic                                rsp_found,
    output logic [ADDR_WIDTH-1:0]               rsp_index,
`ifdef VOCAB_MATCHER_STATS_EN
    output logic [STAT_WIDTH-1:0]               stat_lookups,
    output logic [STAT_WIDTH-1:0]               stat_hits,
`endif
    output logic                                busy
);

    localparam int DEPTH  = 1 << ADDR_WIDTH;
    localparam int W      = DATA_WIDTH * WORD_LENGTH;
    localparam int GROUPS = DEPTH / LANES;
    localparam int GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam int LW     = (LANES > 1) ? $clog2(LANES) : 1;

    state_t                    state_q;
    logic [W-1:0]              word_q;
    logic [GW-1:0]             group_q;
    logic                      primed_q;
    logic                      found_q;
    logic [ADDR_WIDTH-1:0]     index_q;

    logic                      idle;
    logic [LANES-1:0][W-1:0]   rd_words;
    logic [LANES-1:0]          rd_valid;
    logic                      hit;
    logic                      term;
    logic                      last;
    logic                      prefix_ok;
    logic [LW-1:0]             hit_lane;
    logic [ADDR_WIDTH-1:0]     hit_index;

    assign idle = (state_q == IDLE);

    // Writes and clears only take effect in IDLE; clear beats a simultaneous write.
    vocab_store #(
        .DATA_WIDTH (DATA_WIDTH),
        .WORD_LENGTH(WORD_LENGTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .LANES      (LANES),
        .GW         (GW)
    ) u_store (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (idle && clear),
        .wr_en_i   (idle && wr_en && !clear),
        .wr_addr_i (wr_addr),
        .wr_word_i (wr_word),
        .rd_group_i(group_q),
        .rd_words_o(rd_words),
        .rd_valid_o(rd_valid)
    );

    // A lane may only hit if it and every lower lane in the group are valid.
    always_comb begin
        hit       = 1'b0;
        term      = 1'b0;
        prefix_ok = 1'b1;
        hit_lane  = '0;
        for (int l = 0; l < LANES; l++) begin
            prefix_ok = prefix_ok & rd_valid[l];
            if (!rd_valid[l]) begin
                term = 1'b1;
            end
            if (prefix_ok && !hit && (rd_words[l] == word_q)) begin
                hit      = 1'b1;
                hit_lane = LW'(l);
            end
        end
    end

    assign last      = (group_q == GW'(GROUPS - 1));
    assign hit_index = ADDR_WIDTH'(int'(group_q) * LANES + int'(hit_lane));

    // The first SCAN cycle only primes the pipeline, giving group g its decision at k+2+g.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            word_q   <= '0;
            group_q  <= '0;
            primed_q <= 1'b0;
            found_q  <= 1'b0;
            index_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        state_q  <= SCAN;
                        word_q   <= req_word;
                        group_q  <= '0;
                        primed_q <= 1'b0;
                    end
                end
                SCAN: begin
                    if (!primed_q) begin
                        primed_q <= 1'b1;
                    end else if (hit || term || last) begin
                        state_q <= RESP;
                        found_q <= hit;
                        index_q <= hit ? hit_index : '0;
                    end else begin
                        group_q <= group_q + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_q <= IDLE;
                        found_q <= 1'b0;
                        index_q <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready = idle;
    assign rsp_valid = (state_q == RESP);
    assign rsp_found = found_q;
    assign rsp_index = index_q;
    assign busy      = !idle;

`ifdef VOCAB_MATCHER_STATS_EN
    logic [STAT_WIDTH-1:0] lookups_q;
    logic [STAT_WIDTH-1:0] hits_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lookups_q <= '0;
            hits_q    <= '0;
        end else if (rsp_valid && rsp_ready) begin
            if (lookups_q != '1) begin
                lookups_q <= lookups_q + 1'b1;
            end
            if (found_q && (hits_q != '1)) begin
                hits_q <= hits_q + 1'b1;
            end
        end
    end

    assign stat_lookups = lookups_q;
    assign stat_hits    = hits_q;
`endif

endmodule

// File: doc/vocab_matcher.md
Name: vocab_matcher

Overview:
- Parametrised successor to the single-lane matcher.
- Holds a vocabulary of DEPTH words, each WORD_LENGTH characters of DATA_WIDTH bits, in an internal store with a write port.
- On a valid/ready request it scans the vocabulary LANES entries per cycle and returns found plus the lowest matching index over a valid/ready response channel.
- Sits between the tokenizer front end and the token-id consumer.

Parameters:
- DATA_WIDTH, 8, bits per character
- WORD_LENGTH, 3, characters per word; character 0 occupies the MSBs
- ADDR_WIDTH, 4, vocab address width; DEPTH = 2**ADDR_WIDTH
- LANES, 2, entries compared per cycle; power of two, 1 <= LANES <= DEPTH

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- clear  in  1  invalidate all vocab entries (one cycle)
- wr_en  in  1  write vocab entry
- wr_addr  in  ADDR_WIDTH  entry address
- wr_word  in  WORD_LENGTH*DATA_WIDTH  entry data; sets the entry valid bit
- req_valid  in  1  lookup request
- req_ready  out  1  high only in IDLE
- req_word  in  WORD_LENGTH*DATA_WIDTH  word to find
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_found  out  1  match found
- rsp_index  out  ADDR_WIDTH  lowest matching index; 0 when not found
- busy  out  1  state != IDLE

Behaviour:
- Reset (asynchronous, active-low):
  - state=IDLE; all valid bits 0.
  - req_ready=1, rsp_valid=0, rsp_found=0, rsp_index=0, busy=0.
  - Entry data is not reset.
  - Reset mid-scan or mid-response aborts the lookup immediately; no response is issued.
- State machine:
  - IDLE -> SCAN on req_valid&&req_ready. The accepting edge is k; req_word is latched at k.
  - SCAN: group g (entries g*LANES .. g*LANES+LANES-1) is compared in cycle k+1+g.
  - Terminator: an entry is a terminator if its valid bit is 0. The first terminator ends the vocabulary; entries at or after it never match, even if equal.
  - SCAN -> RESP after the group that:
    - contains a match: found=1, index = lowest matching lane; or
    - contains the first terminator: found=0; or
    - is the last group, g = DEPTH/LANES-1: found=0.
  - RESP: rsp_valid=1 with stable rsp_found/rsp_index. Then rsp_valid is first seen high (g+2) cycles after edge k.
  - RESP -> IDLE on rsp_valid&&rsp_ready.
  - Next request is accepted no earlier than the cycle after the response handshake; no overlap.
- Compare rule: full-width bitwise equality of all WORD_LENGTH*DATA_WIDTH bits.
- Write and clear rules:
  - wr_en and clear are honoured only in IDLE; in SCAN or RESP they are dropped silently.
  - clear and wr_en in the same cycle: clear wins; the write is dropped.
  - wr_en and request acceptance in the same IDLE cycle: the write lands first; the scan sees the new entry.
- Empty vocab (entry 0 invalid): response found=0, index=0, after 2 cycles.
- Full vocab (no terminator), miss: response after DEPTH/LANES+1 cycles.

Optional Feature:
- Macro: VOCAB_MATCHER_STATS_EN.
- Defined: adds output ports stat_lookups[31:0] and stat_hits[31:0], both reset to 0.
  - stat_lookups increments on each response handshake.
  - stat_hits increments on each response handshake with rsp_found=1.
  - Both saturate at all-ones; clear does not reset them.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package matcher_pkg:
  - state enum (IDLE, SCAN, RESP);
  - word_t typedef parametrised through localparams matching the defaults;
  - localparam STAT_WIDTH=32.
- Sub-module vocab_store:
  - register array plus valid vector;
  - one write port and a LANES-wide group read port indexed by group number, returning LANES words and LANES valid bits combinationally.
- Compare, terminator priority and lowest-index select live in vocab_matcher.

Test Plan (defaults: DATA_WIDTH=8, WORD_LENGTH=3, DEPTH=16, LANES=2):
- Load entries 0..15 with distinct words, "Hel" (48656C) at 5; request "Hel", rsp_ready=1 -> rsp_valid 4 cycles after accept, found=1, index=5.
- Also write "Hel" at 4 -> index=4 (lowest index within group 2 wins).
- Entries 0..3 valid, 4 invalid, "Hel" at 7 -> found=0, index=0, response 4 cycles after accept.
- All 16 valid, request absent word -> found=0 after 9 cycles; hold rsp_ready=0 for 5 cycles -> rsp_valid, found and index stay stable and req_ready stays 0.
- wr_en and clear asserted during SCAN -> dropped; next lookup of the old word still hits. Then clear in IDLE -> next lookup found=0 after 2 cycles.
- Assert rst_n=0 mid-SCAN -> rsp_valid=0 and req_ready=1 immediately. With VOCAB_MATCHER_STATS_EN, after 3 lookups with 2 hits -> stat_lookups=3, stat_hits=2.
